// File: rtl/bip_control_unit_pkg.sv
// Shared definitions for the accumulator processor control path:
// opcode values, datapath select encodings, FSM states and decode bundles.
package bip_pkg;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_JMP  = 5'b01000;
    localparam logic [4:0] OP_BEQ  = 5'b01001;
    localparam logic [4:0] OP_BNE  = 5'b01010;
    localparam logic [4:0] OP_OUT  = 5'b01011;

    localparam logic [1:0] SELA_RAM     = 2'b00;
    localparam logic [1:0] SELA_OPERAND = 2'b01;
    localparam logic [1:0] SELA_ALU     = 2'b10;
    localparam logic       SELB_RAM     = 1'b0;
    localparam logic       SELB_OPERAND = 1'b1;
    localparam logic       ALU_ADD      = 1'b0;
    localparam logic       ALU_SUB      = 1'b1;

    typedef enum logic [1:0] {
        FETCH     = 2'b00,
        EXEC      = 2'b01,
        WAIT_UART = 2'b10,
        HALT      = 2'b11
    } stateT;

    // Datapath strobes for one instruction, before gating by the FSM
    typedef struct packed {
        logic [1:0] selA;
        logic       selB;
        logic       wrAcc;
        logic       op;
        logic       wrRam;
        logic       rdRam;
    } ctrlT;

    typedef struct packed {
        logic hlt;
        logic jmp;
        logic beq;
        logic bne;
        logic out;
        logic illegal;
    } classT;

endpackage

// File: rtl/bip_control_unit_if.sv
// Bus between the control unit (master) and program memory / datapath / UART (slave).
interface bip_control_unit_if #(
    parameter int AB = 11,
    parameter int CW = 16
);
    logic [4:0]    OpCode;
    logic [AB-1:0] Operand;
    logic          acc_zero;
    logic          uart_busy;
    logic [AB-1:0] Addr;
    logic [1:0]    SelA;
    logic          SelB;
    logic          WrAcc;
    logic          Op;
    logic          WrRam;
    logic          RdRam;
    logic          wr_uart;
    logic          halted;
    logic          illegal;
    logic [CW-1:0] instr_cnt;

    modport master (
        input  OpCode, Operand, acc_zero, uart_busy,
        output Addr, SelA, SelB, WrAcc, Op, WrRam, RdRam, wr_uart, halted, illegal, instr_cnt
    );

    modport slave (
        output OpCode, Operand, acc_zero, uart_busy,
        input  Addr, SelA, SelB, WrAcc, Op, WrRam, RdRam, wr_uart, halted, illegal, instr_cnt
    );
endinterface

// File: rtl/bip_control_unit_decoder.sv
// Purely combinational opcode decode into datapath strobes and instruction class flags.
module bip_instr_decoder
    import bip_pkg::*;
(
    input  logic [4:0] opCode,
    output ctrlT       ctrl,
    output classT      cls
);
    always_comb begin
        ctrl = '0;
        cls  = '0;
        case (opCode)
            OP_HLT:  cls.hlt = 1'b1;
            OP_STO:  ctrl.wrRam = 1'b1;
            OP_LD:   begin ctrl.rdRam = 1'b1; ctrl.wrAcc = 1'b1; ctrl.selA = SELA_RAM; end
            OP_LDI:  begin ctrl.wrAcc = 1'b1; ctrl.selA = SELA_OPERAND; end
            OP_ADD:  begin ctrl.rdRam = 1'b1; ctrl.wrAcc = 1'b1; ctrl.selA = SELA_ALU; ctrl.selB = SELB_RAM; ctrl.op = ALU_ADD; end
            OP_ADDI: begin ctrl.wrAcc = 1'b1; ctrl.selA = SELA_ALU; ctrl.selB = SELB_OPERAND; ctrl.op = ALU_ADD; end
            OP_SUB:  begin ctrl.rdRam = 1'b1; ctrl.wrAcc = 1'b1; ctrl.selA = SELA_ALU; ctrl.selB = SELB_RAM; ctrl.op = ALU_SUB; end
            OP_SUBI: begin ctrl.wrAcc = 1'b1; ctrl.selA = SELA_ALU; ctrl.selB = SELB_OPERAND; ctrl.op = ALU_SUB; end
            OP_JMP:  cls.jmp = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_BNE:  cls.bne = 1'b1;
            OP_OUT:  cls.out = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/bip_control_unit.sv
// Fetch/execute control unit: program counter, FSM with configurable
// instruction-memory latency, UART output stall, halt and retired-instruction counter.
module bip_control_unit
    import bip_pkg::*;
#(
    parameter int AB       = 11,
    parameter int IMEM_LAT = 1,
    parameter int CW       = 16
) (
    input logic clk,
    input logic reset,
    bip_control_unit_if.master bus
);
    localparam logic [2:0] LAT_LAST = 3'(IMEM_LAT - 1);

    stateT         state, nextState;
    logic [2:0]    latCnt;
    logic [AB-1:0] pc, nextPc;
    logic [CW-1:0] instrCnt;
    ctrlT          ctrl, ctrlGated;
    classT         cls;
    logic          retire, uartGo, illegalPulse, branchTaken;

    bip_instr_decoder decoder (
        .opCode(bus.OpCode),
        .ctrl  (ctrl),
        .cls   (cls)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            FETCH:     if (latCnt == LAT_LAST) nextState = EXEC;
            EXEC:      if (cls.hlt) nextState = HALT;
                       else if (cls.out && bus.uart_busy) nextState = WAIT_UART;
                       else nextState = FETCH;
            WAIT_UART: if (!bus.uart_busy) nextState = FETCH;
            HALT:      nextState = HALT;
            default:   nextState = FETCH;
        endcase
    end

    // Strobes exist only in EXEC; the sole exception is the deferred UART write
    always_comb begin
        ctrlGated    = '0;
        uartGo       = 1'b0;
        retire       = 1'b0;
        illegalPulse = 1'b0;
        if (state == EXEC) begin
            ctrlGated    = ctrl;
            illegalPulse = cls.illegal;
            uartGo       = cls.out && !bus.uart_busy;
            retire       = !(cls.out && bus.uart_busy);
        end else if (state == WAIT_UART) begin
            uartGo = !bus.uart_busy;
            retire = !bus.uart_busy;
        end
    end

    always_comb begin
        branchTaken = cls.jmp || (cls.beq && bus.acc_zero) || (cls.bne && !bus.acc_zero);
        nextPc      = pc;
        if (state == EXEC) begin
            if (branchTaken) nextPc = bus.Operand;
            else if (!cls.hlt && !(cls.out && bus.uart_busy)) nextPc = pc + AB'(1);
        end else if (state == WAIT_UART && !bus.uart_busy) begin
            nextPc = pc + AB'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= '0;
        else       pc <= nextPc;
    end

    // Memory wait counter; rearmed on every entry to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  latCnt <= '0;
        else if (state != FETCH)    latCnt <= '0;
        else if (latCnt == LAT_LAST) latCnt <= '0;
        else                        latCnt <= latCnt + 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          instrCnt <= '0;
        else if (retire && instrCnt != '1)  instrCnt <= instrCnt + CW'(1);
    end

    assign bus.Addr      = pc;
    assign bus.SelA      = ctrlGated.selA;
    assign bus.SelB      = ctrlGated.selB;
    assign bus.WrAcc     = ctrlGated.wrAcc;
    assign bus.Op        = ctrlGated.op;
    assign bus.WrRam     = ctrlGated.wrRam;
    assign bus.RdRam     = ctrlGated.rdRam;
    assign bus.wr_uart   = uartGo;
    assign bus.halted    = (state == HALT);
    assign bus.illegal   = illegalPulse;
    assign bus.instr_cnt = instrCnt;
endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: two instances (IMEM_LAT=1/CW=4 and IMEM_LAT=3/CW=16)
// run directed and random programs against an instruction-level reference model.
module tb_bip_control_unit;
    import bip_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetA = 1'b1;
    logic resetB = 1'b1;
    logic az     = 1'b0;
    logic busy   = 1'b0;
    logic [15:0] prog [0:2047];

    int checks  = 0;
    int passed  = 0;
    int azForce = -1;
    int busyRun = -1;

    bip_control_unit_if #(.AB(11), .CW(4))  ifA ();
    bip_control_unit_if #(.AB(11), .CW(16)) ifB ();

    assign ifA.OpCode    = prog[ifA.Addr][15:11];
    assign ifA.Operand   = prog[ifA.Addr][10:0];
    assign ifA.acc_zero  = az;
    assign ifA.uart_busy = busy;
    assign ifB.OpCode    = prog[ifB.Addr][15:11];
    assign ifB.Operand   = prog[ifB.Addr][10:0];
    assign ifB.acc_zero  = az;
    assign ifB.uart_busy = busy;

    bip_control_unit #(.AB(11), .IMEM_LAT(1), .CW(4)) dutA (
        .clk  (clk),
        .reset(resetA),
        .bus  (ifA.master)
    );

    bip_control_unit #(.AB(11), .IMEM_LAT(3), .CW(16)) dutB (
        .clk  (clk),
        .reset(resetB),
        .bus  (ifB.master)
    );

    function automatic logic [36:0] observed(input bit which);
        if (which)
            return {ifB.Addr, ifB.SelA, ifB.SelB, ifB.WrAcc, ifB.Op, ifB.WrRam, ifB.RdRam,
                    ifB.wr_uart, ifB.halted, ifB.illegal, ifB.instr_cnt};
        return {ifA.Addr, ifA.SelA, ifA.SelB, ifA.WrAcc, ifA.Op, ifA.WrRam, ifA.RdRam,
                ifA.wr_uart, ifA.halted, ifA.illegal, 12'b0, ifA.instr_cnt};
    endfunction

    // Expected vector: {Addr, {SelA,SelB,WrAcc,Op,WrRam,RdRam}, wr_uart, halted, illegal, instr_cnt}
    function automatic logic [36:0] pack(input logic [10:0] addr, input logic [6:0] strobes,
                                         input logic wu, input logic h, input logic il, input int cnt);
        return {addr, strobes, wu, h, il, 16'(cnt)};
    endfunction

    function automatic logic [6:0] expStrobes(input logic [4:0] op);
        case (op)
            OP_STO:  return 7'b00_0_0_0_1_0;
            OP_LD:   return 7'b00_0_1_0_0_1;
            OP_LDI:  return 7'b01_0_1_0_0_0;
            OP_ADD:  return 7'b10_0_1_0_0_1;
            OP_ADDI: return 7'b10_1_1_0_0_0;
            OP_SUB:  return 7'b10_0_1_1_0_1;
            OP_SUBI: return 7'b10_1_1_1_0_0;
            default: return 7'b0;
        endcase
    endfunction

    function automatic logic [15:0] randInstr();
        int r;
        logic [4:0] op;
        r = $urandom_range(0, 99);
        if (r < 3)      op = OP_HLT;
        else if (r < 8) op = 5'($urandom_range(12, 31));
        else            op = 5'($urandom_range(1, 11));
        return {op, 11'($urandom)};
    endfunction

    task automatic checkOutput(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic applyStimulus();
        az   = (azForce < 0) ? 1'($urandom_range(0, 1)) : azForce[0];
        busy = 1'($urandom_range(0, 1));
    endtask

    task automatic fillProgram(input logic [15:0] word);
        for (int i = 0; i < 2048; i++) prog[i] = word;
    endtask

    task automatic applyReset(input bit which);
        if (which) resetB = 1'b1;
        else       resetA = 1'b1;
        applyStimulus();
        #1 checkOutput("reset", observed(which), pack(11'd0, 7'b0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
    endtask

    // Instruction-level model: releases reset and executes up to maxInstr instructions
    task automatic runProgram(input bit which, input int maxInstr);
        logic [10:0] pc = 11'd0;
        int cnt = 0;
        int lat = which ? 3 : 1;
        int cmax = which ? 65535 : 15;
        logic [4:0] op;
        logic [10:0] opd;
        logic busyNow, azNow, done;
        int w;
        if (which) resetB = 1'b0;
        else       resetA = 1'b0;
        for (int n = 0; n < maxInstr; n++) begin
            for (int k = 0; k < lat; k++) begin
                applyStimulus();
                #1 checkOutput("fetch", observed(which), pack(pc, 7'b0, 1'b0, 1'b0, 1'b0, cnt));
                @(negedge clk);
            end
            op  = prog[pc][15:11];
            opd = prog[pc][10:0];
            applyStimulus();
            if (busyRun >= 0) busy = (busyRun > 0);
            busyNow = busy;
            azNow   = az;
            #1 checkOutput("exec", observed(which),
                           pack(pc, expStrobes(op), (op == OP_OUT) && !busyNow, 1'b0, op > OP_OUT, cnt));
            @(negedge clk);
            if (op == OP_HLT) begin
                if (cnt < cmax) cnt++;
                repeat (3) begin
                    applyStimulus();
                    #1 checkOutput("halt", observed(which), pack(pc, 7'b0, 1'b0, 1'b1, 1'b0, cnt));
                    @(negedge clk);
                end
                return;
            end
            if (op == OP_OUT && busyNow) begin
                w = 1;
                do begin
                    applyStimulus();
                    if (busyRun >= 0) busy = (w < busyRun);
                    else if (w >= 8)  busy = 1'b0;
                    done = !busy;
                    #1 checkOutput("waitUart", observed(which), pack(pc, 7'b0, done, 1'b0, 1'b0, cnt));
                    @(negedge clk);
                    w++;
                end while (!done);
            end
            if (op == OP_JMP || (op == OP_BEQ && azNow) || (op == OP_BNE && !azNow)) pc = opd;
            else pc = pc + 11'd1;
            if (cnt < cmax) cnt++;
        end
    endtask

    initial begin
        fillProgram(16'h0000);
        @(negedge clk);
        applyReset(1'b0);
        applyReset(1'b1);

        // LDI 5; ADDI 3; STO 7; HLT
        prog[0] = {OP_LDI, 11'd5};
        prog[1] = {OP_ADDI, 11'd3};
        prog[2] = {OP_STO, 11'd7};
        prog[3] = {OP_HLT, 11'd0};
        runProgram(1'b0, 10);
        applyReset(1'b0);

        // Three-cycle memory latency
        fillProgram(16'h0000);
        prog[0] = {OP_LDI, 11'd9};
        runProgram(1'b1, 10);
        applyReset(1'b1);

        // Branches, jump to top of memory and PC wrap
        prog[0]     = {OP_BEQ, 11'h040};
        prog[11'h040] = {OP_BNE, 11'h100};
        azForce = 1;
        runProgram(1'b0, 10);
        applyReset(1'b0);
        prog[1]       = {OP_BNE, 11'h200};
        prog[11'h200] = {OP_JMP, 11'h7FF};
        prog[11'h7FF] = {OP_LDI, 11'h055};
        azForce = 0;
        runProgram(1'b0, 8);
        applyReset(1'b0);
        azForce = -1;

        // OUT stalled by a busy UART for five cycles
        fillProgram(16'h0000);
        prog[0] = {OP_OUT, 11'd0};
        busyRun = 5;
        runProgram(1'b0, 10);
        applyReset(1'b0);

        // Reset landing in WAIT_UART together with busy dropping
        prog[0] = {OP_JMP, 11'd5};
        prog[5] = {OP_OUT, 11'd0};
        resetA = 1'b0;
        applyStimulus();
        #1 checkOutput("rwFetch0", observed(1'b0), pack(11'd0, 7'b0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        applyStimulus();
        #1 checkOutput("rwJmp", observed(1'b0), pack(11'd0, 7'b0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        applyStimulus();
        #1 checkOutput("rwFetch5", observed(1'b0), pack(11'd5, 7'b0, 1'b0, 1'b0, 1'b0, 1));
        @(negedge clk);
        busy = 1'b1;
        #1 checkOutput("rwOutBusy", observed(1'b0), pack(11'd5, 7'b0, 1'b0, 1'b0, 1'b0, 1));
        @(negedge clk);
        busy   = 1'b0;
        resetA = 1'b1;
        #1 checkOutput("rwResetNow", observed(1'b0), pack(11'd0, 7'b0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        prog[0] = {OP_LDI, 11'd1};
        busyRun = -1;
        runProgram(1'b0, 4);
        applyReset(1'b0);

        // Illegal opcode
        fillProgram(16'h0000);
        prog[0] = {5'b11111, 11'd0};
        runProgram(1'b0, 5);
        applyReset(1'b0);

        // Counter saturation on the 4-bit instance
        fillProgram({OP_LDI, 11'd2});
        prog[20] = {OP_HLT, 11'd0};
        runProgram(1'b0, 30);
        applyReset(1'b0);

        // Random programs on both instances
        for (int s = 0; s < 10; s++) begin
            for (int i = 0; i < 2048; i++) prog[i] = randInstr();
            runProgram(s[0], 30);
            applyReset(s[0]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
